// File: rtl/rr_request_agent.sv
// Requester-side agent for the round-robin arbiter: counts pending events per client,
// holds requests until served, and turns valid grants into one-hot acks.
// Optional per-client watchdog compiled in with `define RR_REQ_WATCHDOG_EN.
module rr_request_agent #(
  parameter int N       = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [N-1:0]         evt_valid,
  output logic [N-1:0]         evt_ready,
  output logic [N-1:0]         request,
  input  logic                 grant,
  input  logic [$clog2(N)-1:0] grant_id,
  output logic [N-1:0]         gnt_ack,
  output logic                 busy,
  output logic                 err_spurious,
  input  logic                 err_clear,
  output logic [N-1:0]         timeout
);

  localparam int ID_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("rr_request_agent: N must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rr_request_agent: TIMEOUT must be at least 1");
  end

  logic [N-1:0][CNT_W-1:0] pend_q, pend_d;
  logic [N-1:0]            gnt_ack_q, gnt_ack_d;
  logic                    err_spurious_q, err_spurious_d;

  logic [N-1:0] gv;       // grant that actually retires an event this cycle
  logic [N-1:0] acc;      // event accepted this cycle
  logic [N-1:0] nz;       // client has at least one pending event
  logic         spurious;

  // NOTE: every combinational output gets a default before the loop, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    gv        = '0;
    acc       = '0;
    nz        = '0;
    evt_ready = '0;
    request   = '0;
    pend_d    = pend_q;
    for (int i = 0; i < N; i++) begin
      nz[i]        = (pend_q[i] != '0);
      evt_ready[i] = (pend_q[i] != CNT_MAX);
      acc[i]       = evt_valid[i] & evt_ready[i];
      gv[i]        = grant & (grant_id == ID_W'(i)) & nz[i];
      if (acc[i] && !gv[i]) begin
        pend_d[i] = pend_q[i] + CNT_ONE;
      end else if (gv[i] && !acc[i]) begin
        pend_d[i] = pend_q[i] - CNT_ONE;
      end
      // Hide the event being retired right now so the arbiter cannot grant it twice.
      request[i] = gv[i] ? (pend_q[i] > CNT_ONE) : nz[i];
    end
  end

  always_comb begin
    spurious       = grant & ~nz[grant_id];
    err_spurious_d = spurious | (err_spurious_q & ~err_clear);
    gnt_ack_d      = gv;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order. Reset is asynchronous and clears
  // all counters, which deliberately discards any outstanding events.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pend_q         <= '0;
      gnt_ack_q      <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      pend_q         <= pend_d;
      gnt_ack_q      <= gnt_ack_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign busy         = |nz;
  assign gnt_ack      = gnt_ack_q;
  assign err_spurious = err_spurious_q;

`ifdef RR_REQ_WATCHDOG_EN
  localparam int AGE_W = $clog2(TIMEOUT) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  logic [N-1:0][AGE_W-1:0] age_q, age_d;
  logic [N-1:0]            timeout_q, timeout_d;

  // Age counts cycles a client has waited without being served; it restarts on
  // every retire and whenever the client goes idle.
  always_comb begin
    age_d     = '0;
    timeout_d = '0;
    for (int i = 0; i < N; i++) begin
      if (nz[i] && !gv[i]) begin
        age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + AGE_W'(1);
      end
      timeout_d[i] = (age_d[i] == AGE_MAX) | (timeout_q[i] & ~err_clear);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      age_q     <= '0;
      timeout_q <= '0;
    end else begin
      age_q     <= age_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = '0;
`endif

endmodule
